// File: rtl/flash_rom_loader.sv
// Boot-time copier: streams WORD_COUNT 16-bit words from the SPI flash reader into
// on-chip RAM, keeps a running mod-2^16 checksum and reports done or timeout error.
module flash_rom_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h100000,
  parameter int unsigned WORD_COUNT = 16384,
  parameter int unsigned MEM_AW     = 14,
  parameter logic [19:0] TIMEOUT    = 20'hFFFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum,
  output logic              flash_valid,
  output logic [23:0]       flash_addr,
  input  logic              flash_ready,
  input  logic [15:0]       flash_rdata,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_wait
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] LAST_WORD  = 16'(WORD_COUNT - 1);
  localparam logic [19:0] TIMER_LAST = TIMEOUT - 20'd1;

  state_t      state;
  state_t      state_next;
  logic [15:0] word_cnt;
  logic [19:0] timer;

  logic start_ok;
  logic got_word;
  logic timed_out;
  logic write_done;
  logic last_word;

  always_comb begin
    start_ok   = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    got_word   = (state == S_REQ) && flash_ready;
    timed_out  = (state == S_REQ) && !flash_ready && (timer == TIMER_LAST);
    write_done = (state == S_WRITE) && !mem_wait;
    last_word  = (word_cnt == LAST_WORD);
  end

  // NOTE: state lives in flops with async reset and non-blocking updates; every
  // strobe below is decoded from it, so reset forces them low without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: default assignment first, so no path through the case leaves
  // state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_ok) state_next = S_REQ;
      end
      S_REQ: begin
        if (got_word)       state_next = S_WRITE;
        else if (timed_out) state_next = S_ERROR;
      end
      S_WRITE: begin
        if (write_done) state_next = last_word ? S_DONE : S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Leaving REQ on the ready edge drops flash_valid in that same edge, and WRITE
  // always separates two requests, so valid is never high together with mem_we.
  always_comb begin
    busy        = (state == S_REQ) || (state == S_WRITE);
    flash_valid = (state == S_REQ);
    mem_we      = (state == S_WRITE);
    done        = (state == S_DONE);
    error       = (state == S_ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_addr <= FLASH_BASE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      checksum   <= '0;
      word_cnt   <= '0;
      timer      <= '0;
    end else begin
      if (start_ok) begin
        flash_addr <= FLASH_BASE;
        mem_addr   <= '0;
        checksum   <= '0;
        word_cnt   <= '0;
        timer      <= '0;
      end

      if (state == S_REQ) begin
        if (flash_ready) begin
          mem_wdata <= flash_rdata;
          timer     <= '0;
        end else begin
          timer <= timer + 20'd1;
        end
      end

      // The checksum of the last word lands on the same edge that enters DONE.
      if (write_done) begin
        checksum   <= checksum + mem_wdata;
        word_cnt   <= word_cnt + 16'd1;
        mem_addr   <= mem_addr + MEM_AW'(1);
        flash_addr <= flash_addr + 24'd2;
        timer      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flash_rom_loader.sv
// Directed bench for flash_rom_loader: behavioural flash reader and stalling RAM,
// a table of copy runs plus hand-written timeout, reset and restart sequences.
module tb_flash_rom_loader;

  localparam int          WC  = 4;
  localparam int          AW  = 4;
  localparam logic [19:0] TO  = 20'd16;
  localparam int          LAT = 3;
  localparam logic [15:0] EXP_SUM = 16'h1410;  // 0201+0403+0605+0807

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          busy, done, error;
  logic [15:0]   checksum;
  logic          flash_valid;
  logic [23:0]   flash_addr;
  logic          flash_ready;
  logic [15:0]   flash_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_wait;

  flash_rom_loader #(
    .FLASH_BASE(24'h000000),
    .WORD_COUNT(WC),
    .MEM_AW    (AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum),
    .flash_valid(flash_valid),
    .flash_addr (flash_addr),
    .flash_ready(flash_ready),
    .flash_rdata(flash_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wait   (mem_wait)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int i);
    logic [7:0] lo;
    lo = 8'(2 * i + 1);
    return {lo + 8'd1, lo};
  endfunction

  // Environment state shared with the sequences.
  logic        flash_en = 1'b1;
  int          lat = 0;
  int          stall_word = -1;
  int          stall_left = 0;
  int          hs_bad = 0;
  int          writes = 0;
  int          we_cycles[16];
  logic [15:0] ram[16];
  logic [23:0] addr_log[$];
  logic        prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0] prev_wdata = '0;

  // Flash reader model and handshake / RAM-port monitors, all away from posedge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (flash_ready && flash_valid) hs_bad++;
      if (flash_valid && mem_we) hs_bad++;
      if (mem_we && prev_we && (mem_addr != prev_addr || mem_wdata != prev_wdata)) hs_bad++;
    end
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;

    if (flash_ready) begin
      flash_ready = 1'b0;
    end else if (flash_en && flash_valid) begin
      lat++;
      if (lat >= LAT) begin
        flash_ready = 1'b1;
        flash_rdata = {flash_addr[7:0] + 8'd2, flash_addr[7:0] + 8'd1};
        addr_log.push_back(flash_addr);
        lat = 0;
      end
    end else begin
      lat = 0;
    end

    if (mem_we) we_cycles[mem_addr]++;
    if (mem_we && int'(mem_addr) == stall_word && stall_left > 0) begin
      mem_wait = 1'b1;
      stall_left--;
    end else begin
      mem_wait = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset_n && mem_we && !mem_wait) begin
      ram[mem_addr] = mem_wdata;
      writes++;
    end
  end

  task automatic clear_log();
    addr_log.delete();
    writes = 0;
    hs_bad = 0;
    for (int i = 0; i < 16; i++) begin
      we_cycles[i] = 0;
      ram[i] = 16'hxxxx;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int n = 0;
    while (!done && !error && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("copy_finished", done | error, 1);
  endtask

  task automatic check_copy(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_checksum"}, checksum, EXP_SUM);
    check({tag, "_writes"}, writes, WC);
    check({tag, "_reqs"}, addr_log.size(), WC);
    for (int i = 0; i < WC; i++) begin
      check({tag, "_ram"}, ram[i], exp_word(i));
      if (i < addr_log.size()) check({tag, "_faddr"}, addr_log[i], 2 * i);
    end
    check({tag, "_handshake"}, hs_bad, 0);
  endtask

  typedef struct {
    string name;
    int    stall_word;
    int    stall_len;
    int    watch_word;
    int    exp_we_cycles;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{"plain",    -1, 0, 0, 1};
    vecs[1] = '{"stall_w1",  1, 3, 1, 4};
    vecs[2] = '{"stall_w3",  3, 1, 3, 2};

    reset_n = 1'b0;
    start = 1'b0;
    flash_ready = 1'b0;
    flash_rdata = '0;
    mem_wait = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_valid", flash_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_faddr", flash_addr, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_checksum", checksum, 0);
    @(negedge clk) reset_n = 1'b1;

    // Table-driven copy runs with different RAM stall patterns.
    for (int v = 0; v < 3; v++) begin
      clear_log();
      stall_word = vecs[v].stall_word;
      stall_left = vecs[v].stall_len;
      pulse_start();
      check({vecs[v].name, "_busy_after_start"}, busy, 1);
      wait_end(300);
      check_copy(vecs[v].name);
      check({vecs[v].name, "_we_cycles"}, we_cycles[vecs[v].watch_word], vecs[v].exp_we_cycles);
      check({vecs[v].name, "_maddr_end"}, mem_addr, WC);
      check({vecs[v].name, "_faddr_end"}, flash_addr, 2 * WC);
    end
    stall_word = -1;

    // Restart from DONE clears done and checksum on the next cycle.
    clear_log();
    pulse_start();
    check("restart_done_clr", done, 0);
    check("restart_busy", busy, 1);
    check("restart_sum_clr", checksum, 0);

    // Start pulsed mid-copy must not restart the transfer.
    begin
      int n = 0;
      while (!(flash_valid && mem_addr == 1) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reach_word1", flash_valid && mem_addr == 1, 1);
    end
    pulse_start();
    wait_end(300);
    check_copy("start_while_busy");

    // Flash never answers: error after TIMEOUT cycles in REQ.
    flash_en = 1'b0;
    clear_log();
    pulse_start();
    begin
      int n = 0;
      while (!error && n < 100) begin
        if (flash_valid) n++;
        @(negedge clk);
      end
      check("timeout_req_cycles", n, 16);
    end
    check("timeout_error", error, 1);
    check("timeout_busy", busy, 0);
    check("timeout_done", done, 0);
    check("timeout_valid", flash_valid, 0);
    flash_en = 1'b1;
    clear_log();
    pulse_start();
    check("err_clr_on_start", error, 0);
    check("err_restart_busy", busy, 1);
    wait_end(300);
    check_copy("after_error");

    // Reset while word 2 is stalled in WRITE; strobes must drop without a clock.
    clear_log();
    stall_word = 2;
    stall_left = 5;
    pulse_start();
    begin
      int n = 0;
      while (!(mem_we && mem_addr == 2) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reach_word2", mem_we && mem_addr == 2, 1);
    end
    reset_n = 1'b0;
    #1;
    check("arst_mem_we", mem_we, 0);
    check("arst_valid", flash_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_checksum", checksum, 0);
    check("arst_maddr", mem_addr, 0);
    check("arst_faddr", flash_addr, 0);
    check("arst_done", done, 0);
    stall_word = -1;
    stall_left = 0;
    @(negedge clk) reset_n = 1'b1;
    clear_log();
    pulse_start();
    wait_end(300);
    check_copy("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
